// File: rtl/ssd_decoder.sv
// rtl/ssd_decoder.sv - recovers a 4-digit frame from a scanned 7-segment display bus
// Samples anode/segment lines, debounces them, decodes each digit and publishes complete frames.
module ssd_decoder #(
   parameter int STABLE_CNT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  Anode,
   input  logic [6:0]  LED_out,
   input  logic        err_clr,
   output logic [15:0] digits,
   output logic        frame_valid,
   output logic [7:0]  frame_cnt,
   output logic        seg_err,
   output logic        anode_err
);

   localparam logic [3:0] STABLE = 4'(STABLE_CNT);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t      state;
   logic [10:0] sample;
   logic [3:0]  stab_cnt;
   logic [3:0]  stab_nxt;
   logic        acc;
   logic [15:0] shadow;
   logic [3:0]  seen;

   logic [3:0]  s_an;
   logic [6:0]  s_led;
   logic [3:0]  an_low;
   logic [3:0]  nib;
   logic        legal;
   logic        an_single;
   logic        an_blank;
   logic        frame_done;
   logic        slot_wr;
   logic        seg_set;
   logic        an_set;

   assign s_an   = sample[10:7];
   assign s_led  = sample[6:0];
   assign an_low = ~s_an;

   always_comb begin
      stab_nxt = 4'd1;
      if ({Anode, LED_out} == sample) begin
         if (stab_cnt == STABLE)
            stab_nxt = STABLE;
         else
            stab_nxt = stab_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample   <= '1;
         stab_cnt <= 4'd0;
         acc      <= 1'b0;
      end else begin
         sample   <= {Anode, LED_out};
         stab_cnt <= stab_nxt;
         // Fires only on the crossing, so a long stable window yields one acceptance.
         acc      <= (stab_nxt == STABLE) && (stab_cnt != STABLE);
      end
   end

   always_comb begin
      nib   = 4'hF;
      legal = 1'b1;
      case (s_led)
         7'b0000001: nib = 4'h0;
         7'b1001111: nib = 4'h1;
         7'b0010010: nib = 4'h2;
         7'b0000110: nib = 4'h3;
         7'b1001100: nib = 4'h4;
         7'b0100100: nib = 4'h5;
         7'b0100000: nib = 4'h6;
         7'b0001111: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0000100: nib = 4'h9;
         7'b1111111: nib = 4'hF;
         default:    legal = 1'b0;
      endcase
   end

   assign an_blank   = (s_an == 4'hF);
   assign an_single  = !an_blank && ((an_low & (an_low - 4'd1)) == 4'd0);
   assign frame_done = (state == COLLECT) && (seen == 4'hF);
   // Writes are held off on the publish edge so the seen clear never collides with a new slot.
   assign slot_wr    = acc && an_single && legal && !frame_done;
   assign seg_set    = acc && !an_blank && !legal;
   assign an_set     = acc && !an_blank && !an_single;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         shadow      <= 16'h0000;
         seen        <= 4'h0;
         digits      <= 16'h0000;
         frame_valid <= 1'b0;
         frame_cnt   <= 8'h00;
         seg_err     <= 1'b0;
         anode_err   <= 1'b0;
      end else begin
         if (seg_set)
            seg_err <= 1'b1;
         else if (err_clr)
            seg_err <= 1'b0;

         if (an_set)
            anode_err <= 1'b1;
         else if (err_clr)
            anode_err <= 1'b0;

         if (slot_wr) begin
            for (int k = 0; k < 4; k++) begin
               if (an_low[k]) begin
                  shadow[4*k +: 4] <= nib;
                  seen[k]          <= 1'b1;
               end
            end
         end

         frame_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (slot_wr || seen != 4'h0)
                  state <= COLLECT;
            end
            COLLECT: begin
               if (seen == 4'hF) begin
                  state       <= DONE;
                  digits      <= shadow;
                  frame_valid <= 1'b1;
                  frame_cnt   <= frame_cnt + 8'd1;
                  seen        <= 4'h0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ssd_decoder.sv
// tb/tb_ssd_decoder.sv - directed self-checking bench for ssd_decoder
module tb_ssd_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  Anode = 4'hF;
   logic [6:0]  LED_out = 7'h7F;
   logic        err_clr = 1'b0;
   logic [15:0] digits;
   logic        frame_valid;
   logic [7:0]  frame_cnt;
   logic        seg_err;
   logic        anode_err;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          fv_cycles = 0;
   int          dig_bad = 0;
   int          fv0;
   logic [15:0] dig_prev = 16'h0000;

   always #5 clk = ~clk;

   ssd_decoder #(.STABLE_CNT(4)) dut (
      .clk(clk), .reset(reset), .Anode(Anode), .LED_out(LED_out), .err_clr(err_clr),
      .digits(digits), .frame_valid(frame_valid), .frame_cnt(frame_cnt),
      .seg_err(seg_err), .anode_err(anode_err)
   );

   always @(negedge clk) begin
      if (frame_valid === 1'b1) fv_cycles++;
      if (reset === 1'b1 && frame_valid !== 1'b1 && digits !== dig_prev) dig_bad++;
      dig_prev = digits;
   end

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic show(input int k, input int d, input int n);
      Anode   = ~(4'b0001 << k);
      LED_out = seg_of(d);
      repeat (n) @(negedge clk);
   endtask

   task automatic blank(input int n);
      Anode   = 4'hF;
      LED_out = 7'h7F;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL reset_digits: got %h expected 0000", digits); end
      n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
      n_cmp++; if (frame_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_cnt: got %h expected 00", frame_cnt); end
      n_cmp++; if (seg_err !== 1'b0) begin n_bad++; $display("FAIL reset_seg_err: got %b expected 0", seg_err); end
      n_cmp++; if (anode_err !== 1'b0) begin n_bad++; $display("FAIL reset_anode_err: got %b expected 0", anode_err); end
      reset = 1'b1;
      blank(2);
   endtask

   task automatic test_basic;
      fv0 = fv_cycles;
      show(3, 1, 8); blank(2);
      show(2, 2, 8); blank(2);
      show(1, 3, 8); blank(2);
      show(0, 4, 8); blank(4);
      n_cmp++; if (fv_cycles - fv0 !== 1) begin n_bad++; $display("FAIL basic_fv_pulse: got %0d expected 1", fv_cycles - fv0); end
      n_cmp++; if (digits !== 16'h1234) begin n_bad++; $display("FAIL basic_digits: got %h expected 1234", digits); end
      n_cmp++; if (frame_cnt !== 8'h01) begin n_bad++; $display("FAIL basic_cnt: got %h expected 01", frame_cnt); end
      n_cmp++; if (seg_err !== 1'b0 || anode_err !== 1'b0) begin n_bad++; $display("FAIL basic_errs: got %b%b expected 00", seg_err, anode_err); end
   endtask

   task automatic test_glitch;
      fv0 = fv_cycles;
      show(3, 5, 8); blank(2);
      show(2, 6, 8); blank(2);
      show(1, 7, 8); blank(2);
      show(0, 8, 3); blank(4);
      n_cmp++; if (fv_cycles - fv0 !== 0) begin n_bad++; $display("FAIL glitch_short_fv: got %0d expected 0", fv_cycles - fv0); end
      n_cmp++; if (digits !== 16'h1234) begin n_bad++; $display("FAIL glitch_short_digits: got %h expected 1234", digits); end
      show(0, 8, 4); blank(4);
      n_cmp++; if (fv_cycles - fv0 !== 1) begin n_bad++; $display("FAIL glitch_hold_fv: got %0d expected 1", fv_cycles - fv0); end
      n_cmp++; if (digits !== 16'h5678) begin n_bad++; $display("FAIL glitch_hold_digits: got %h expected 5678", digits); end
      n_cmp++; if (frame_cnt !== 8'h02) begin n_bad++; $display("FAIL glitch_cnt: got %h expected 02", frame_cnt); end
   endtask

   task automatic test_illegal;
      fv0 = fv_cycles;
      Anode = 4'b1110; LED_out = 7'b1010101;
      repeat (8) @(negedge clk);
      blank(4);
      n_cmp++; if (seg_err !== 1'b1) begin n_bad++; $display("FAIL illegal_seg_err: got %b expected 1", seg_err); end
      n_cmp++; if (anode_err !== 1'b0) begin n_bad++; $display("FAIL illegal_anode_err: got %b expected 0", anode_err); end
      n_cmp++; if (fv_cycles - fv0 !== 0) begin n_bad++; $display("FAIL illegal_no_frame: got %0d expected 0", fv_cycles - fv0); end
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      n_cmp++; if (seg_err !== 1'b0) begin n_bad++; $display("FAIL illegal_clr: got %b expected 0", seg_err); end
      Anode = 4'b1110; LED_out = 7'b1010101;
      repeat (4) @(negedge clk);
      n_cmp++; if (seg_err !== 1'b0) begin n_bad++; $display("FAIL illegal_pre_set: got %b expected 0", seg_err); end
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      n_cmp++; if (seg_err !== 1'b1) begin n_bad++; $display("FAIL illegal_set_wins: got %b expected 1", seg_err); end
      blank(4);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      n_cmp++; if (seg_err !== 1'b0) begin n_bad++; $display("FAIL illegal_clr2: got %b expected 0", seg_err); end
   endtask

   task automatic test_anode_fault;
      Anode = 4'b1100; LED_out = seg_of(3);
      repeat (8) @(negedge clk);
      blank(4);
      n_cmp++; if (anode_err !== 1'b1) begin n_bad++; $display("FAIL anode_err_set: got %b expected 1", anode_err); end
      n_cmp++; if (seg_err !== 1'b0) begin n_bad++; $display("FAIL anode_seg_err: got %b expected 0", seg_err); end
      n_cmp++; if (digits !== 16'h5678) begin n_bad++; $display("FAIL anode_digits: got %h expected 5678", digits); end
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      n_cmp++; if (anode_err !== 1'b0) begin n_bad++; $display("FAIL anode_clr: got %b expected 0", anode_err); end
   endtask

   task automatic test_overwrite;
      show(0, 5, 8); blank(2);
      show(0, 7, 8); blank(2);
      show(1, 3, 8); blank(2);
      show(2, 2, 8); blank(2);
      show(3, 1, 8); blank(4);
      n_cmp++; if (digits[3:0] !== 4'h7) begin n_bad++; $display("FAIL overwrite_slot0: got %h expected 7", digits[3:0]); end
      n_cmp++; if (digits !== 16'h1237) begin n_bad++; $display("FAIL overwrite_digits: got %h expected 1237", digits); end
      n_cmp++; if (frame_cnt !== 8'h03) begin n_bad++; $display("FAIL overwrite_cnt: got %h expected 03", frame_cnt); end
   endtask

   task automatic test_wrap;
      fv0 = fv_cycles;
      for (int f = 0; f < 252; f++) begin
         show(3, 4, 4); blank(1);
         show(2, 3, 4); blank(1);
         show(1, 2, 4); blank(1);
         show(0, 1, 4); blank(1);
      end
      blank(4);
      n_cmp++; if (frame_cnt !== 8'hFF) begin n_bad++; $display("FAIL wrap_ff: got %h expected ff", frame_cnt); end
      show(3, 4, 4); blank(1);
      show(2, 3, 4); blank(1);
      show(1, 2, 4); blank(1);
      show(0, 1, 4); blank(4);
      n_cmp++; if (frame_cnt !== 8'h00) begin n_bad++; $display("FAIL wrap_00: got %h expected 00", frame_cnt); end
      n_cmp++; if (fv_cycles - fv0 !== 253) begin n_bad++; $display("FAIL wrap_frames: got %0d expected 253", fv_cycles - fv0); end
      n_cmp++; if (digits !== 16'h4321) begin n_bad++; $display("FAIL wrap_digits: got %h expected 4321", digits); end
   endtask

   task automatic test_reset_mid;
      show(3, 1, 8); blank(2);
      show(2, 2, 8); blank(2);
      reset = 1'b0;
      blank(2);
      n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_digits: got %h expected 0000", digits); end
      n_cmp++; if (frame_cnt !== 8'h00) begin n_bad++; $display("FAIL mid_reset_cnt: got %h expected 00", frame_cnt); end
      n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_fv: got %b expected 0", frame_valid); end
      reset = 1'b1;
      fv0 = fv_cycles;
      show(1, 7, 8); blank(2);
      show(0, 6, 8); blank(4);
      n_cmp++; if (fv_cycles - fv0 !== 0) begin n_bad++; $display("FAIL mid_partial_fv: got %0d expected 0", fv_cycles - fv0); end
      show(3, 9, 8); blank(2);
      show(2, 8, 8); blank(4);
      n_cmp++; if (digits !== 16'h9876) begin n_bad++; $display("FAIL mid_digits: got %h expected 9876", digits); end
      n_cmp++; if (frame_cnt !== 8'h01) begin n_bad++; $display("FAIL mid_cnt: got %h expected 01", frame_cnt); end
      n_cmp++; if (fv_cycles - fv0 !== 1) begin n_bad++; $display("FAIL mid_fv: got %0d expected 1", fv_cycles - fv0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_illegal();
      test_anode_fault();
      test_overwrite();
      test_wrap();
      test_reset_mid();
      n_cmp++; if (dig_bad !== 0) begin n_bad++; $display("FAIL digits_stable: got %0d changes outside frame_valid expected 0", dig_bad); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
